// File: rtl/fft_reorder.sv
// rtl/fft_reorder.sv - ping-pong bit-reversal reorder buffer for radix-2 FFT output
module fft_reorder #(
  parameter int DATA_WIDTH = 9,
  parameter int N_LOG2     = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_real,
  input  logic signed [DATA_WIDTH-1:0] in_imag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_real,
  output logic signed [DATA_WIDTH-1:0] out_imag,
  output logic        [N_LOG2-1:0]     out_index,
  output logic                         out_last
);

  localparam int N = 1 << N_LOG2;
  localparam logic [N_LOG2-1:0] LAST = N_LOG2'(N - 1);

  logic signed [DATA_WIDTH-1:0] mem_real [2][N];
  logic signed [DATA_WIDTH-1:0] mem_imag [2][N];

  logic              wr_bank, rd_bank;
  logic [N_LOG2-1:0] wcnt, rcnt;
  logic [1:0]        bank_full, bank_full_next;
  logic              wr_fire, load;

  function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] v);
    logic [N_LOG2-1:0] r;
    for (int i = 0; i < N_LOG2; i++) r[i] = v[N_LOG2-1-i];
    return r;
  endfunction

  assign in_ready = !bank_full[wr_bank];
  assign wr_fire  = in_valid && in_ready;
  assign load     = bank_full[rd_bank] && (!out_valid || out_ready);

  // A set needs the flag clear and a clear needs it set, so both edits never hit one bank.
  always_comb begin
    bank_full_next = bank_full;
    if (wr_fire && wcnt == LAST) bank_full_next[wr_bank] = 1'b1;
    if (load && rcnt == LAST)    bank_full_next[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_real[wr_bank][bitrev(wcnt)] <= in_real;
      mem_imag[wr_bank][bitrev(wcnt)] <= in_imag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wcnt      <= '0;
      rcnt      <= '0;
      bank_full <= '0;
    end else begin
      bank_full <= bank_full_next;
      if (wr_fire) begin
        wcnt <= wcnt + 1'b1;
        if (wcnt == LAST) wr_bank <= ~wr_bank;
      end
      if (load) begin
        rcnt <= rcnt + 1'b1;
        if (rcnt == LAST) rd_bank <= ~rd_bank;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_index <= '0;
      out_real  <= '0;
      out_imag  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_real  <= mem_real[rd_bank][rcnt];
      out_imag  <= mem_imag[rd_bank][rcnt];
      out_index <= rcnt;
      out_last  <= (rcnt == LAST);
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_reorder.sv
// tb/tb_fft_reorder.sv - directed and scoreboard bench for fft_reorder
module tb_fft_reorder;

  localparam int DW = 9;
  localparam int NL = 3;
  localparam int N  = 1 << NL;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_real, in_imag;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_real, out_imag;
  logic [NL-1:0]        out_index;
  logic                 out_last;

  fft_reorder #(.DATA_WIDTH(DW), .N_LOG2(NL)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_real(in_real), .in_imag(in_imag),
    .out_valid(out_valid), .out_ready(out_ready), .out_real(out_real), .out_imag(out_imag),
    .out_index(out_index), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [DW-1:0] ir, ii;
    logic signed [DW-1:0] er, ei;
    logic [NL-1:0]        eidx;
    logic                 elast;
  } vec_t;

  typedef struct {
    logic signed [DW-1:0] re, im;
    logic [NL-1:0]        idx;
  } samp_t;

  int checks = 0;
  int errors = 0;
  int n_cons, n_acc, fr_n;
  samp_t sbq[$];
  logic signed [DW-1:0] fr_re [N];
  logic signed [DW-1:0] fr_im [N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NL-1:0] rev(input logic [NL-1:0] v);
    logic [NL-1:0] r;
    for (int i = 0; i < NL; i++) r[i] = v[NL-1-i];
    return r;
  endfunction

  task automatic flush_model();
    sbq.delete();
    fr_n = 0; n_cons = 0; n_acc = 0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    flush_model();
  endtask

  // One clock of stimulus with scoreboard tracking of both handshakes and stall stability.
  task automatic cycle(input logic vi, input logic signed [DW-1:0] re, input logic signed [DW-1:0] im,
                       input logic ordy);
    logic acc, cons, stall, slast;
    logic signed [DW-1:0] sre, sim;
    logic [NL-1:0] sidx;
    samp_t e;
    in_valid = vi; in_real = re; in_imag = im; out_ready = ordy;
    #1;
    acc = in_valid && in_ready;
    cons = out_valid && out_ready;
    stall = out_valid && !out_ready;
    sre = out_real; sim = out_imag; sidx = out_index; slast = out_last;
    if (cons) begin
      n_cons++;
      if (sbq.size() == 0) check("sb_unexpected_output", 32'd1, 32'd0);
      else begin
        e = sbq.pop_front();
        check("sb_real", out_real, e.re);
        check("sb_imag", out_imag, e.im);
        check("sb_index", out_index, e.idx);
        check("sb_last", out_last, e.idx == NL'(N - 1));
      end
    end
    @(posedge clk); #1;
    if (acc) begin
      n_acc++;
      fr_re[fr_n] = re; fr_im[fr_n] = im; fr_n++;
      if (fr_n == N) begin
        for (int j = 0; j < N; j++) begin
          e.re = fr_re[rev(NL'(j))]; e.im = fr_im[rev(NL'(j))]; e.idx = NL'(j);
          sbq.push_back(e);
        end
        fr_n = 0;
      end
    end
    if (stall) begin
      check("stall_valid", out_valid, 1'b1);
      check("stall_real", out_real, sre);
      check("stall_imag", out_imag, sim);
      check("stall_index", out_index, sidx);
      check("stall_last", out_last, slast);
    end
  endtask

  vec_t tbl [N];

  initial begin
    tbl[0] = '{0,  0, 0,  0, 0, 0};
    tbl[1] = '{1, -1, 4, -4, 1, 0};
    tbl[2] = '{2, -2, 2, -2, 2, 0};
    tbl[3] = '{3, -3, 6, -6, 3, 0};
    tbl[4] = '{4, -4, 1, -1, 4, 0};
    tbl[5] = '{5, -5, 5, -5, 5, 0};
    tbl[6] = '{6, -6, 3, -3, 6, 0};
    tbl[7] = '{7, -7, 7, -7, 7, 1};

    // Reset values
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_real = '0; in_imag = '0;
    flush_model();
    #3;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_out_index", out_index, '0);
    check("rst_out_real", out_real, '0);
    check("rst_out_imag", out_imag, '0);
    check("rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", in_ready, 1'b1);
    check("post_rst_out_valid", out_valid, 1'b0);

    // Single frame, table driven
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1; in_real = tbl[i].ir; in_imag = tbl[i].ii;
      check("tbl_in_ready", in_ready, 1'b1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("tbl_latency_early", out_valid, 1'b0);
    @(posedge clk); #1;
    for (int j = 0; j < N; j++) begin
      check("tbl_out_valid", out_valid, 1'b1);
      check("tbl_out_real", out_real, tbl[j].er);
      check("tbl_out_imag", out_imag, tbl[j].ei);
      check("tbl_out_index", out_index, tbl[j].eidx);
      check("tbl_out_last", out_last, tbl[j].elast);
      @(posedge clk); #1;
    end
    check("tbl_drained", out_valid, 1'b0);

    // Back-to-back frames
    do_reset();
    for (int i = 0; i < 43; i++) begin
      if (i < 32) check("b2b_in_ready", in_ready, 1'b1);
      check("b2b_out_valid", out_valid, (i >= 9 && i <= 40));
      cycle(i < 32, DW'(i), DW'($urandom), 1'b1);
    end
    check("b2b_count", n_cons, 32);

    // Backpressure until both banks are full
    do_reset();
    for (int i = 0; i < 20; i++) begin
      check("bp_in_ready", in_ready, i < 16);
      cycle(1'b1, DW'(i + 100), DW'(-i), 1'b0);
    end
    check("bp_accepted", n_acc, 16);
    check("bp_out_valid", out_valid, 1'b1);
    check("bp_out_index", out_index, '0);
    check("bp_out_real", out_real, DW'(100));
    for (int i = 0; i < 20; i++) begin
      if (out_valid && n_cons < N && out_index == NL'(N - 2)) check("bp_not_freed", in_ready, 1'b0);
      if (out_valid && n_cons < N && out_index == NL'(N - 1)) check("bp_freed", in_ready, 1'b1);
      cycle(1'b0, '0, '0, 1'b1);
    end
    check("bp_drained", n_cons, 16);
    check("bp_sb_empty", sbq.size(), 0);

    // Random stalls with signed random data
    do_reset();
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 1)), DW'($urandom), DW'($urandom), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 40; i++) cycle(1'b0, '0, '0, 1'b1);
    check("rnd_count", n_cons, (n_acc / N) * N);
    check("rnd_sb_empty", sbq.size(), 0);

    // Reset mid-operation
    do_reset();
    for (int i = 0; i < 13; i++) cycle(1'b1, DW'($urandom), DW'($urandom), 1'b1);
    check("mid_draining", out_valid, 1'b1);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    check("mid_rst_index", out_index, '0);
    flush_model();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < N; i++) cycle(1'b1, DW'($urandom), DW'($urandom), 1'b1);
    for (int i = 0; i < 12; i++) cycle(1'b0, '0, '0, 1'b1);
    check("mid_count", n_cons, N);
    check("mid_sb_empty", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_reorder.md
# fft_reorder

Bit-reversal reorder buffer that sits at the output of the radix-2 FFT datapath, downstream of the `Butterfly` stages. It accepts complex FFT results in bit-reversed bin order, one sample per cycle, and streams them out in natural bin order (0..N-1) with a valid/ready handshake. Two frame banks are used in ping-pong fashion, so one frame can be written while the previous one is read.

## Interface
- `DATA_WIDTH`, default 9: width of each real and imaginary sample. This matches the butterfly output width of input width + 1.
- `N_LOG2`, default 3: log2 of the FFT size. N = 1<<N_LOG2, so the default is 8 points.
- `clk` input, 1 bit: single clock; all logic is rising-edge.
- `rst` input, 1 bit: reset. Asynchronous and active-high.
- `in_valid` input, 1 bit: an input sample is presented.
- `in_ready` output, 1 bit: the block can accept a sample. A transfer occurs when `in_valid` and `in_ready` are both high at a rising edge.
- `in_real`, `in_imag` input, DATA_WIDTH bits, signed: FFT result, in bit-reversed bin order.
- `out_valid` output, 1 bit: output registers hold a valid sample.
- `out_ready` input, 1 bit: the downstream block accepts the sample.
- `out_real`, `out_imag` output, DATA_WIDTH bits, signed: sample, in natural bin order.
- `out_index` output, N_LOG2 bits: bin number of the current output sample.
- `out_last` output, 1 bit: high on the sample with bin N-1.

## Operation
- **Storage:** `mem[2][N]` complex words, with combinational read. Memory contents are not reset.
- **State registers:**
  - `wr_bank` and `rd_bank`, 1 bit each.
  - `wcnt` and `rcnt`, N_LOG2 bits each.
  - `bank_full[1:0]`.
- **Write side:**
  - `in_ready = !bank_full[wr_bank]`. This is combinational from registers only.
  - On each transfer: write `mem[wr_bank][bitrev(wcnt)]`, then increment `wcnt`.
  - When the transfer has `wcnt == N-1`: set `bank_full[wr_bank]`, toggle `wr_bank`, and wrap `wcnt` to 0.
- **Read side:**
  - Load condition: `bank_full[rd_bank] && (!out_valid || out_ready)`.
  - On load:
    - `out_real`/`out_imag` ← `mem[rd_bank][rcnt]`.
    - `out_index` ← `rcnt`.
    - `out_last` ← `(rcnt == N-1)`.
    - `out_valid` ← 1.
    - Increment `rcnt`.
  - On a load with `rcnt == N-1`: clear `bank_full[rd_bank]`, toggle `rd_bank`, and wrap `rcnt` to 0.
  - When there is no load but `out_valid && out_ready`: `out_valid` ← 0.
- **Stall rule:** while `out_valid && !out_ready`, all output registers hold their values.
- **Bank flag conflicts:** setting and clearing the same bank flag in one cycle cannot occur. A set requires the flag to be 0 (`in_ready` high); a clear requires the flag to be 1. Set of one bank and clear of the other in the same cycle are both honoured.
- **`bitrev`:** reverses the order of the N_LOG2 bits. For example, with N_LOG2=3, 1→4 and 3→6.
- **Arithmetic:** none. Data passes through bit-exact at DATA_WIDTH. No saturation and no scaling.

## Timing
- **Reset:** while `rst` is asserted, asynchronously:
  - `out_valid`=0, `out_last`=0, `out_index`=0, `out_real`=0, `out_imag`=0.
  - `wcnt`=`rcnt`=0, `wr_bank`=`rd_bank`=0, `bank_full`=0.
  - Hence `in_ready`=1.
- **Reset mid-frame:** the partial input frame and any buffered frames are discarded. `out_valid` drops immediately.
- **Latency:** the last sample of a frame is accepted at edge k. `out_valid` (bin 0) is high after edge k+1.
- **Throughput:** with `out_ready` held high, bins 1..N-1 follow on consecutive cycles. Sustained throughput is 1 sample/cycle with no bubbles between frames.
- **Full condition:** when both banks are full, `in_ready`=0.
- **Freed bank:** a bank freed by the read of bin N-1 at edge m becomes writable in the cycle after edge m. There is no same-cycle bypass.
- **Input side:** `in_valid` may toggle arbitrarily. Gaps in input do not corrupt frame alignment.
- **Output side:** `out_ready` may deassert at any cycle, including on `out_last`.

## Test plan
1. **Reset values:** assert `rst` → all outputs are 0 and `in_ready`=1. Release `rst` → `in_ready` stays 1.
2. **Single-frame reorder:** N=8, `out_ready`=1, feed `in_real` = 0..7 (and `in_imag` = -0..-7) on consecutive cycles.
   - Expect `out_real` = 0,4,2,6,1,5,3,7 and `out_index` = 0..7.
   - Expect `out_last` only on index 7.
   - First `out_valid` occurs 1 cycle after the 8th input is accepted.
3. **Back-to-back frames:** stream 4 frames with `in_valid`=1 and `out_ready`=1 continuously.
   - Expect `in_ready` to stay 1 throughout.
   - Expect output to be continuous for 32 cycles, correctly reordered per frame.
4. **Backpressure / full:** hold `out_ready`=0 and stream inputs.
   - `in_ready` falls after exactly 16 accepted samples.
   - `out_valid`=1 holds bin 0 of frame 0 unchanged.
   - Release `out_ready` → 16 samples drain in order.
   - `in_ready` returns 1 the cycle after frame 0's bin 7 is read.
5. **Random stalls:** random `in_valid` and `out_ready` (50% duty) with signed random data.
   - The scoreboard matches a bit-reversal reference model.
   - No sample is lost or duplicated.
   - Output holds stable while stalled.
6. **Reset mid-operation:** assert `rst` after 5 samples of frame 1 while frame 0 is draining.
   - `out_valid`=0 immediately.
   - The next full frame after release is output correctly starting at `out_index` 0.
